// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/freeze control
// and saturating stall/flush event counters.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_ID_i,
  input  logic [4:0]  rt_ID_i,
  input  logic [4:0]  rd_ID_i,
  input  logic [31:0] rs_data_ID_i,
  input  logic [31:0] rt_data_ID_i,
  input  logic [31:0] imm_ID_i,
  input  logic [9:0]  ctrl_ID_i,
  input  logic        uses_rt_ID_i,
  input  logic        valid_ID_i,
  input  logic        flush_i,
  input  logic        freeze_i,
  output logic [4:0]  rs_EX_o,
  output logic [4:0]  rt_EX_o,
  output logic [4:0]  rd_EX_o,
  output logic [31:0] rs_data_EX_o,
  output logic [31:0] rt_data_EX_o,
  output logic [31:0] imm_EX_o,
  output logic [9:0]  ctrl_EX_o,
  output logic        valid_EX_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        stall_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam int unsigned REG_W        = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CTRL_W       = 10;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned CTRL_MEMREAD = 1;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } ex_reg_t;

  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic             hazard;

  // Load in EX whose destination is a live source of the ID instruction; r0 never hazards.
  always_comb begin
    hazard = ex_q.valid & ex_q.ctrl[CTRL_MEMREAD] & (ex_q.rt != '0) & valid_ID_i &
             ((ex_q.rt == rs_ID_i) | (uses_rt_ID_i & (ex_q.rt == rt_ID_i)));
  end

  assign stall_o     = hazard & ~flush_i & ~freeze_i;
  assign PCWrite_o   = ~(stall_o | freeze_i);
  assign IFIDWrite_o = ~(stall_o | freeze_i);

  // Register update priority: flush, freeze, stall bubble, normal load.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (freeze_i) begin
      ex_d = ex_q;
    end else if (stall_o) begin
      ex_d = '0;
    end else begin
      ex_d.rs      = rs_ID_i;
      ex_d.rt      = rt_ID_i;
      ex_d.rd      = rd_ID_i;
      ex_d.rs_data = rs_data_ID_i;
      ex_d.rt_data = rt_data_ID_i;
      ex_d.imm     = imm_ID_i;
      ex_d.ctrl    = valid_ID_i ? ctrl_ID_i : '0;
      ex_d.valid   = valid_ID_i;
    end
  end

  // Saturating event counters; a flush counts even while frozen.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign rs_EX_o      = ex_q.rs;
  assign rt_EX_o      = ex_q.rt;
  assign rd_EX_o      = ex_q.rd;
  assign rs_data_EX_o = ex_q.rs_data;
  assign rt_data_EX_o = ex_q.rt_data;
  assign imm_EX_o     = ex_q.imm;
  assign ctrl_EX_o    = ex_q.ctrl;
  assign valid_EX_o   = ex_q.valid;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when a step is
// driven and popped for comparison after the clock edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [9:0]  ctrl;
    logic        valid;
  } ex_t;

  localparam logic [9:0] C_LW   = 10'h01B;
  localparam logic [9:0] C_ADD  = 10'h0A1;
  localparam logic [9:0] C_ADDI = 10'h011;
  localparam int K_LOAD = 0;
  localparam int K_BUBBLE = 1;
  localparam int K_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  rs_ID_i, rt_ID_i, rd_ID_i;
  logic [31:0] rs_data_ID_i, rt_data_ID_i, imm_ID_i;
  logic [9:0]  ctrl_ID_i;
  logic        uses_rt_ID_i, valid_ID_i, flush_i, freeze_i;
  logic [4:0]  rs_EX_o, rt_EX_o, rd_EX_o;
  logic [31:0] rs_data_EX_o, rt_data_EX_o, imm_EX_o;
  logic [9:0]  ctrl_EX_o;
  logic        valid_EX_o, PCWrite_o, IFIDWrite_o, stall_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;
  ex_t sb_q[$];
  ex_t last_e = '0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .rs_ID_i(rs_ID_i), .rt_ID_i(rt_ID_i), .rd_ID_i(rd_ID_i),
    .rs_data_ID_i(rs_data_ID_i), .rt_data_ID_i(rt_data_ID_i), .imm_ID_i(imm_ID_i),
    .ctrl_ID_i(ctrl_ID_i), .uses_rt_ID_i(uses_rt_ID_i), .valid_ID_i(valid_ID_i),
    .flush_i(flush_i), .freeze_i(freeze_i),
    .rs_EX_o(rs_EX_o), .rt_EX_o(rt_EX_o), .rd_EX_o(rd_EX_o),
    .rs_data_EX_o(rs_data_EX_o), .rt_data_EX_o(rt_data_EX_o), .imm_EX_o(imm_EX_o),
    .ctrl_EX_o(ctrl_EX_o), .valid_EX_o(valid_EX_o),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t ex_obs();
    return '{rs_EX_o, rt_EX_o, rd_EX_o, rs_data_EX_o, rt_data_EX_o, imm_EX_o, ctrl_EX_o, valid_EX_o};
  endfunction

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [9:0] ctrl,
                        input logic urt, input logic vld);
    @(negedge clk);
    rs_ID_i = rs; rt_ID_i = rt; rd_ID_i = rd;
    rs_data_ID_i = rsd; rt_data_ID_i = rsd ^ 32'h5A5A_0000; imm_ID_i = {27'd0, rd} + 32'h100;
    ctrl_ID_i = ctrl; uses_rt_ID_i = urt; valid_ID_i = vld;
    flush_i = 1'b0; freeze_i = 1'b0;
  endtask

  // Check combinational outputs, queue the expected EX state, clock, then compare.
  task automatic cyc(input string tag, input logic e_stall, input logic e_pc, input int kind,
                     input logic [15:0] e_sc, input logic [15:0] e_fc);
    ex_t e;
    ex_t got;
    #1;
    chk({tag, ".stall"}, 128'(stall_o), 128'(e_stall));
    chk({tag, ".pcwrite"}, 128'(PCWrite_o), 128'(e_pc));
    chk({tag, ".ifidwrite"}, 128'(IFIDWrite_o), 128'(e_pc));
    case (kind)
      K_LOAD:   e = '{rs_ID_i, rt_ID_i, rd_ID_i, rs_data_ID_i, rt_data_ID_i, imm_ID_i,
                      valid_ID_i ? ctrl_ID_i : 10'd0, valid_ID_i};
      K_BUBBLE: e = '0;
      default:  e = last_e;
    endcase
    last_e = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = ex_obs();
    e = sb_q.pop_front();
    chk({tag, ".ex"}, 128'(got), 128'(e));
    chk({tag, ".stall_cnt"}, 128'(stall_cnt_o), 128'(e_sc));
    chk({tag, ".flush_cnt"}, 128'(flush_cnt_o), 128'(e_fc));
  endtask

  initial begin
    rst_i = 1'b0;
    rs_ID_i = 5'd5; rt_ID_i = 5'd5; rd_ID_i = 5'd1;
    rs_data_ID_i = 32'hDEAD_BEEF; rt_data_ID_i = 32'h1234_5678; imm_ID_i = 32'hFFFF_FFFC;
    ctrl_ID_i = C_LW; uses_rt_ID_i = 1'b1; valid_ID_i = 1'b1; flush_i = 1'b0; freeze_i = 1'b0;
    #12;
    chk("reset.ex", 128'(ex_obs()), 128'(0));
    chk("reset.stall_cnt", 128'(stall_cnt_o), 128'(0));
    chk("reset.flush_cnt", 128'(flush_cnt_o), 128'(0));
    chk("reset.stall", 128'(stall_o), 128'(0));
    chk("reset.pcwrite", 128'(PCWrite_o), 128'(1));
    chk("reset.ifidwrite", 128'(IFIDWrite_o), 128'(1));
    @(negedge clk);
    rst_i = 1'b1;

    set_id(5'd1, 5'd5, 5'd0, 32'h0000_1000, C_LW, 1'b0, 1'b1);
    cyc("lw5_load", 1'b0, 1'b1, K_LOAD, 16'd0, 16'd0);
    set_id(5'd5, 5'd2, 5'd3, 32'h0000_2000, C_ADD, 1'b1, 1'b1);
    cyc("loaduse_stall", 1'b1, 1'b0, K_BUBBLE, 16'd1, 16'd0);
    cyc("after_stall", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd0);

    set_id(5'd2, 5'd0, 5'd0, 32'h0000_3000, C_LW, 1'b0, 1'b1);
    cyc("lw0_load", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd0);
    set_id(5'd0, 5'd7, 5'd0, 32'h0000_4000, C_LW, 1'b0, 1'b1);
    cyc("r0_nostall", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd0);
    set_id(5'd1, 5'd7, 5'd4, 32'h0000_5000, C_ADDI, 1'b0, 1'b1);
    cyc("rt_unused_nostall", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd0);
    set_id(5'd9, 5'd9, 5'd9, 32'h0000_6000, 10'h3FF, 1'b1, 1'b0);
    cyc("invalid_ctrl_zero", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd0);

    set_id(5'd3, 5'd6, 5'd0, 32'h0000_7000, C_LW, 1'b0, 1'b1);
    cyc("lw6_load", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd0);
    set_id(5'd6, 5'd2, 5'd3, 32'h0000_8000, C_ADD, 1'b1, 1'b1);
    flush_i = 1'b1;
    cyc("flush_over_stall", 1'b0, 1'b1, K_BUBBLE, 16'd1, 16'd1);

    set_id(5'd4, 5'd8, 5'd0, 32'h0000_9000, C_LW, 1'b0, 1'b1);
    cyc("lw8_load", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd1);
    for (int i = 0; i < 3; i++) begin
      set_id(5'd1, 5'd2, 5'd3, 32'hA000_0000 + 32'(i), C_ADD, 1'b1, 1'b1);
      freeze_i = 1'b1;
      cyc("freeze_hold", 1'b0, 1'b0, K_HOLD, 16'd1, 16'd1);
    end
    set_id(5'd1, 5'd2, 5'd3, 32'hA000_0007, C_ADD, 1'b1, 1'b1);
    cyc("freeze_release", 1'b0, 1'b1, K_LOAD, 16'd1, 16'd1);
    set_id(5'd1, 5'd2, 5'd3, 32'hA000_0008, C_ADD, 1'b1, 1'b1);
    flush_i = 1'b1; freeze_i = 1'b1;
    cyc("flush_while_frozen", 1'b0, 1'b0, K_BUBBLE, 16'd1, 16'd2);

    // Preload the stall counter near saturation instead of issuing 65534 stalls.
    set_id(5'd0, 5'd5, 5'd0, 32'h0000_B000, C_LW, 1'b0, 1'b1);
    dut.stall_cnt_q = 16'hFFFD;
    cyc("sat_lw_load", 1'b0, 1'b1, K_LOAD, 16'hFFFD, 16'd2);
    set_id(5'd5, 5'd5, 5'd0, 32'h0000_C000, C_LW, 1'b0, 1'b1);
    cyc("sat_stall1", 1'b1, 1'b0, K_BUBBLE, 16'hFFFE, 16'd2);
    cyc("sat_load1", 1'b0, 1'b1, K_LOAD, 16'hFFFE, 16'd2);
    cyc("sat_stall2", 1'b1, 1'b0, K_BUBBLE, 16'hFFFF, 16'd2);
    cyc("sat_load2", 1'b0, 1'b1, K_LOAD, 16'hFFFF, 16'd2);
    cyc("sat_stall3", 1'b1, 1'b0, K_BUBBLE, 16'hFFFF, 16'd2);
    cyc("sat_load3", 1'b0, 1'b1, K_LOAD, 16'hFFFF, 16'd2);

    // Assert reset mid-cycle while a load-use stall is active.
    set_id(5'd5, 5'd1, 5'd2, 32'h0000_D000, C_ADD, 1'b1, 1'b1);
    #1;
    chk("pre_reset.stall", 128'(stall_o), 128'(1));
    chk("pre_reset.pcwrite", 128'(PCWrite_o), 128'(0));
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_reset.ex", 128'(ex_obs()), 128'(0));
    chk("async_reset.stall_cnt", 128'(stall_cnt_o), 128'(0));
    chk("async_reset.flush_cnt", 128'(flush_cnt_o), 128'(0));
    chk("async_reset.stall", 128'(stall_o), 128'(0));
    chk("async_reset.pcwrite", 128'(PCWrite_o), 128'(1));
    @(negedge clk);
    rst_i = 1'b1;
    last_e = '0;
    set_id(5'd5, 5'd5, 5'd0, 32'h0000_E000, C_LW, 1'b0, 1'b1);
    cyc("post_reset_load", 1'b0, 1'b1, K_LOAD, 16'd0, 16'd0);
    cyc("post_reset_stall", 1'b1, 1'b0, K_BUBBLE, 16'd1, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
